// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Types and default widths shared by the channel phase
//                counter and the downstream wave generators.
//                  phase_state_t : counter FSM states {IDLE, RUN}
//                  PHASE_W       : default phase ramp width
//                  DIV_W         : default note divider width
//  Revision    : 1.0  initial release
// ============================================================================
package synth_pkg;

  localparam int PHASE_W = 6;
  localparam int DIV_W   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } phase_state_t;

endpackage
`default_nettype wire

// File: rtl/channel_phase_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : channel_phase_counter_if
//  Description : Note handshake and phase ramp bus of one channel.
//                  note_valid/note_div/note_ready : divider handshake
//                  gate                           : channel enable
//                  period/wrap/active             : phase ramp outputs
//                master modport = note source / ramp consumer side
//                slave  modport = channel_phase_counter side
//  Revision    : 1.0  initial release
// ============================================================================
interface channel_phase_counter_if #(
  parameter int M = 6,
  parameter int D = 16
) ();

  logic         note_valid;
  logic [D-1:0] note_div;
  logic         note_ready;
  logic         gate;
  logic [M-1:0] period;
  logic         wrap;
  logic         active;

  modport master (
    output note_valid, note_div, gate,
    input  note_ready, period, wrap, active
  );

  modport slave (
    input  note_valid, note_div, gate,
    output note_ready, period, wrap, active
  );

endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Clock divider producing the phase-step tick. Counts clocks
//                and flags the cycle where the count reaches div-1.
//  Ports       : clk  in  system clock
//                rst  in  asynchronous active-high reset
//                clr  in  hold the count at zero
//                div  in  clocks per tick (0 never ticks)
//                tick out combinational, high on the last clock of a period
//  Revision    : 1.0  initial release
// ============================================================================
module tick_divider
  import synth_pkg::*;
#(
  parameter int D = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [D-1:0] div,
  output logic         tick
);

  logic [D-1:0] div_cnt_q;
  logic [D-1:0] div_cnt_d;

  always_comb begin
    tick      = (div != '0) && (div_cnt_q == div - D'(1));
    div_cnt_d = div_cnt_q + D'(1);
    if (clr || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/channel_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : channel_phase_counter
//  Description : Phase ramp generator for one channel. Advances period by
//                one every cur_div clocks while gated; note changes are
//                taken on a valid/ready handshake and applied at step
//                boundaries.
//  Ports       : clk  in  system clock
//                rst  in  asynchronous active-high reset
//                bus  slave modport of channel_phase_counter_if
//                     (note_valid, note_div, note_ready, gate,
//                      period, wrap, active)
//  Config      : PHASE_HARD_SYNC_EN - when defined, a note accepted in RUN
//                restarts the ramp at the next edge instead of waiting for
//                a step boundary; note_ready is then always 1.
//  Revision    : 1.0  initial release
// ============================================================================
module channel_phase_counter
  import synth_pkg::*;
#(
  parameter int M = PHASE_W,
  parameter int D = DIV_W
) (
  input  logic                    clk,
  input  logic                    rst,
  channel_phase_counter_if.slave  bus
);

  phase_state_t state_q, state_d;
  logic [D-1:0] cur_div_q, cur_div_d;
  logic [D-1:0] pend_div_q, pend_div_d;
  logic         pend_vld_q, pend_vld_d;
  logic [M-1:0] period_q, period_d;
  logic         wrap_q, wrap_d;

  logic note_ready;
  logic accept;
  logic run;
  logic exit_run;
  logic sync;
  logic step;
  logic clr;
  logic tick;

`ifdef PHASE_HARD_SYNC_EN
  assign note_ready = 1'b1;
`else
  assign note_ready = !pend_vld_q;
`endif

  tick_divider #(.D(D)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .div  (cur_div_q),
    .tick (tick)
  );

  // Event decode. Leaving RUN (gate low or a zero divider) outranks a step
  // so the ramp never advances on the cycle it is being shut down.
  always_comb begin
    run      = (state_q == RUN);
    accept   = bus.note_valid && note_ready;
    exit_run = run && (!bus.gate || (cur_div_q == '0));
`ifdef PHASE_HARD_SYNC_EN
    sync     = run && !exit_run && accept;
`else
    sync     = 1'b0;
`endif
    step     = run && !exit_run && !sync && tick;
    clr      = !run || exit_run || sync;
  end

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    period_d   = period_q;
    wrap_d     = 1'b0;
    case (state_q)
      IDLE: begin
        period_d = '0;
        if (accept) begin
          cur_div_d = bus.note_div;
        end
        // Start decision uses the registered divider, not one arriving now.
        if (bus.gate && (cur_div_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (exit_run) begin
          state_d    = IDLE;
          period_d   = '0;
          pend_vld_d = 1'b0;
          if (accept) begin
            cur_div_d = bus.note_div;
          end else if (pend_vld_q) begin
            cur_div_d = pend_div_q;
          end
        end else if (sync) begin
          cur_div_d = bus.note_div;
          period_d  = '0;
        end else if (step) begin
          period_d   = period_q + M'(1);
          wrap_d     = (period_q == '1);
          pend_vld_d = 1'b0;
          // A pending divider blocks new accepts, so at most one applies.
          if (pend_vld_q) begin
            cur_div_d = pend_div_q;
          end else if (accept) begin
            cur_div_d = bus.note_div;
          end
        end else if (accept) begin
          pend_div_d = bus.note_div;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_div_q  <= '0;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.note_ready = note_ready;
  assign bus.period     = period_q;
  assign bus.wrap       = wrap_q;
  assign bus.active     = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_channel_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_phase_counter
//  Description : Randomized scoreboard bench for channel_phase_counter.
//                A timeline reference model predicts the outputs after each
//                edge; a separate monitor compares them at the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_channel_phase_counter;
  import synth_pkg::*;

  localparam int M    = PHASE_W;
  localparam int D    = DIV_W;
  localparam int PMOD = 1 << M;

  logic clk = 1'b0;
  logic rst = 1'b1;

  channel_phase_counter_if #(.M(M), .D(D)) bus ();

  channel_phase_counter #(.M(M), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] period;
    logic         wrap;
    logic         active;
    logic         ready;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_off = 1'b1;
  int   wraps_seen = 0;
  int   stalls_seen = 0;

  // Reference model: the ramp is a timeline. Entering RUN at edge e with
  // divider c schedules the next step at edge e+c; each step reschedules.
  bit m_run;
  int m_cur;
  int m_pend[$];
  int m_phase;
  bit m_wrap;
  int m_next;
  int m_edge;
  bit m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cur = 0; m_pend.delete(); m_phase = 0;
    m_wrap = 0; m_next = 0; m_edge = 0; m_acc = 0;
  endtask

  function automatic bit model_ready();
`ifdef PHASE_HARD_SYNC_EN
    return 1'b1;
`else
    return (m_pend.size() == 0);
`endif
  endfunction

  task automatic model_edge(input bit g, input bit nv, input int nd);
    exp_t e;
    bit   start;
    m_acc  = nv && model_ready();
    m_wrap = 0;
    if (!m_run) begin
      start   = g && (m_cur != 0);
      m_phase = 0;
      if (m_acc) m_cur = nd;
      if (start) begin
        m_run  = 1;
        m_next = m_edge + m_cur;
      end
    end else if (!g || m_cur == 0) begin
      m_run   = 0;
      m_phase = 0;
      if (m_acc) m_cur = nd;
      else if (m_pend.size() > 0) m_cur = m_pend.pop_front();
      m_pend.delete();
    end
`ifdef PHASE_HARD_SYNC_EN
    else if (m_acc) begin
      m_cur   = nd;
      m_phase = 0;
      m_next  = m_edge + nd;
    end
`endif
    else if (m_edge == m_next) begin
      m_wrap  = (m_phase == PMOD - 1);
      m_phase = (m_phase + 1) % PMOD;
      if (m_pend.size() > 0) m_cur = m_pend.pop_front();
      else if (m_acc) m_cur = nd;
      m_next = m_edge + m_cur;
    end else if (m_acc) begin
      m_pend.push_back(nd);
    end
    m_edge++;
    e.period = M'(m_phase);
    e.wrap   = m_wrap;
    e.active = m_run;
    e.ready  = model_ready();
    sb.push_back(e);
  endtask

  function automatic logic [D-1:0] pick(input int maxdiv, input int zero_pct);
    if ($urandom_range(99) < zero_pct) return '0;
    return D'($urandom_range(maxdiv, 1));
  endfunction

  // Monitor: one expectation per edge, compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_off && sb.size() > 0) begin
        e = sb.pop_front();
        chk("period", 32'(bus.period), 32'(e.period));
        chk("wrap", 32'(bus.wrap), 32'(e.wrap));
        chk("active", 32'(bus.active), 32'(e.active));
        chk("note_ready", 32'(bus.note_ready), 32'(e.ready));
        if (bus.wrap) wraps_seen++;
        if (!bus.note_ready) stalls_seen++;
      end
    end
  end

  task automatic run_cycles(input int n, input int maxdiv, input int zero_pct,
                            input int offer_pct, input int gate_flip_pm);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge(bus.gate, bus.note_valid, int'(bus.note_div));
      #2;
      if ($urandom_range(999) < gate_flip_pm) bus.gate = !bus.gate;
      if (bus.note_valid && !m_acc) begin
        // offered but not taken: hold note_div stable
      end else if ($urandom_range(99) < offer_pct) begin
        bus.note_valid = 1'b1;
        bus.note_div   = pick(maxdiv, zero_pct);
      end else begin
        bus.note_valid = 1'b0;
        bus.note_div   = D'($urandom);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_period"}, 32'(bus.period), 0);
    chk({tag, "_wrap"}, 32'(bus.wrap), 0);
    chk({tag, "_active"}, 32'(bus.active), 0);
    chk({tag, "_ready"}, 32'(bus.note_ready), 1);
  endtask

  initial begin
    bit hit;
    bus.note_valid = 1'b0;
    bus.note_div   = '0;
    bus.gate       = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst_init");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    mon_off = 1'b0;
    // Start-up: note 3 with gate high, then a randomized mostly-steady run.
    bus.note_valid = 1'b1;
    bus.note_div   = D'(3);
    bus.gate       = 1'b1;
    run_cycles(400, 3, 0, 4, 1);
    // Fastest rate, long enough for several wraps.
    run_cycles(600, 1, 0, 2, 1);
    // Mid-run asynchronous reset at period 37.
    bus.gate       = 1'b1;
    bus.note_valid = 1'b1;
    bus.note_div   = D'(1);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk);
      model_edge(bus.gate, bus.note_valid, int'(bus.note_div));
      #2;
      if (m_acc) bus.note_valid = 1'b0;
      if (m_run && m_phase == 37) hit = 1;
    end
    chk("reach_period_37", 32'(hit), 1);
    #1;
    chk("pre_rst_period", 32'(bus.period), 37);
    rst = 1'b1;
    mon_off = 1'b1;
    sb.delete();
    #1;
    check_reset_values("rst_mid");
    bus.note_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    rst = 1'b0;
    mon_off = 1'b0;
    // Wide mix: retunes, back-pressure, zero dividers, gate toggling.
    run_cycles(1500, 12, 6, 25, 8);
    run_cycles(800, 4, 3, 40, 4);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("wrap_observed", 32'(wraps_seen > 0), 1);
`ifndef PHASE_HARD_SYNC_EN
    chk("backpressure_observed", 32'(stalls_seen > 0), 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
